// File: rtl/lockstep_pkg.sv
// Shared encodings, default sizes and the MSB-first register slice helper for the lockstep checker.
// Latency: none (declarations only); backpressure: not applicable.
package lockstep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 32;

    // Register 0 sits in the most significant slice of a flattened bus.
    function automatic int reg_lsb(input int idx, input int num_regs, input int data_w);
        return (num_regs - 1 - idx) * data_w;
    endfunction

endpackage

// File: rtl/lockstep_diff.sv
// Combinational per-register compare: masked mismatch vector, popcount, lowest mismatching index.
// Latency: 0 cycles; backpressure: none, purely combinational.
module lockstep_diff
    import lockstep_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int DATA_W   = DEF_DATA_W,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int PC_W     = $clog2(NUM_REGS + 1)
) (
    input  logic [NUM_REGS*DATA_W-1:0] i_vreg,
    input  logic [NUM_REGS*DATA_W-1:0] i_creg,
    input  logic [NUM_REGS-1:0]        i_mask,
    output logic [NUM_REGS-1:0]        o_diff,
    output logic [PC_W-1:0]            o_popcnt,
    output logic [IDX_W-1:0]           o_first_idx,
    output logic                       o_any
);

    logic [NUM_REGS-1:0] w_diff;
    logic [PC_W-1:0]     w_pop;
    logic [IDX_W-1:0]    w_idx;

    always_comb begin
        w_diff = '0;
        w_pop  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_diff[i] = i_mask[i] &
                (i_vreg[reg_lsb(i, NUM_REGS, DATA_W) +: DATA_W] !=
                 i_creg[reg_lsb(i, NUM_REGS, DATA_W) +: DATA_W]);
            w_pop = w_pop + PC_W'(w_diff[i]);
        end
    end

    // Scanning downwards lets the lowest set index win.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign o_diff      = w_diff;
    assign o_popcnt    = w_pop;
    assign o_first_idx = w_idx;
    assign o_any       = |w_diff;

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep register-file comparator: counts steps, accumulates mismatches, captures first divergence and a snapshot.
// Latency: results visible 1 cycle after the sampling edge, done 1 cycle after the final step; no backpressure.
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int CYC_W    = 32,
    parameter  int CNT_W    = 16,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       step,
    input  logic [CYC_W-1:0]           num_cycles,
    input  logic [CYC_W-1:0]           snap_cycle,
    input  logic [NUM_REGS-1:0]        mask,
    input  logic [NUM_REGS*DATA_W-1:0] vreg,
    input  logic [NUM_REGS*DATA_W-1:0] creg,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CYC_W-1:0]           cycles,
    output logic [CNT_W-1:0]           mismatch_cnt,
    output logic                       first_valid,
    output logic [CYC_W-1:0]           first_cycle,
    output logic [IDX_W-1:0]           first_reg,
    output logic [DATA_W-1:0]          first_vdata,
    output logic [DATA_W-1:0]          first_cdata,
    output logic [NUM_REGS-1:0]        sticky,
    output logic                       snap_valid,
    output logic [NUM_REGS*DATA_W-1:0] snap_vreg,
    output logic [NUM_REGS*DATA_W-1:0] snap_creg
);

    localparam int PC_W  = $clog2(NUM_REGS + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t r_state;
    state_t w_next;

    logic [CYC_W-1:0]           r_cycles;
    logic [CNT_W-1:0]           r_mcnt;
    logic                       r_pass;
    logic                       r_first_valid;
    logic [CYC_W-1:0]           r_first_cycle;
    logic [IDX_W-1:0]           r_first_reg;
    logic [DATA_W-1:0]          r_first_vdata;
    logic [DATA_W-1:0]          r_first_cdata;
    logic [NUM_REGS-1:0]        r_sticky;
    logic                       r_snap_valid;
    logic [NUM_REGS*DATA_W-1:0] r_snap_vreg;
    logic [NUM_REGS*DATA_W-1:0] r_snap_creg;

    logic [NUM_REGS-1:0] w_diff;
    logic [PC_W-1:0]     w_pop;
    logic [IDX_W-1:0]    w_first_idx;
    logic                w_any;

    logic                w_start_acc;
    logic                w_step_acc;
    logic                w_end;
    logic                w_to_done;
    logic [CYC_W-1:0]    w_cyc_n;
    logic [SUM_W-1:0]    w_sum;
    logic [CNT_W-1:0]    w_mcnt_nxt;
    logic [DATA_W-1:0]   w_first_vdata;
    logic [DATA_W-1:0]   w_first_cdata;

    lockstep_diff #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_diff (
        .i_vreg      (vreg),
        .i_creg      (creg),
        .i_mask      (mask),
        .o_diff      (w_diff),
        .o_popcnt    (w_pop),
        .o_first_idx (w_first_idx),
        .o_any       (w_any)
    );

    // stop outranks a coincident step, so the step is not counted.
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_step_acc  = (r_state == RUN) && step && !stop;
    assign w_cyc_n     = (&r_cycles) ? r_cycles : r_cycles + CYC_W'(1);
    assign w_end       = (num_cycles != '0) && (w_cyc_n == num_cycles);

    assign w_sum      = SUM_W'(r_mcnt) + SUM_W'(w_pop);
    assign w_mcnt_nxt = !w_step_acc               ? r_mcnt  :
                        (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

    assign w_first_vdata = vreg[reg_lsb(int'(w_first_idx), NUM_REGS, DATA_W) +: DATA_W];
    assign w_first_cdata = creg[reg_lsb(int'(w_first_idx), NUM_REGS, DATA_W) +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_to_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (stop || (w_step_acc && w_end)) begin
                    w_next    = DONE;
                    w_to_done = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles      <= '0;
            r_mcnt        <= '0;
            r_pass        <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_cycle <= '0;
            r_first_reg   <= '0;
            r_first_vdata <= '0;
            r_first_cdata <= '0;
            r_sticky      <= '0;
            r_snap_valid  <= 1'b0;
            r_snap_vreg   <= '0;
            r_snap_creg   <= '0;
        end else begin
            if (w_start_acc) begin
                r_cycles      <= '0;
                r_mcnt        <= '0;
                r_pass        <= 1'b0;
                r_first_valid <= 1'b0;
                r_first_cycle <= '0;
                r_first_reg   <= '0;
                r_first_vdata <= '0;
                r_first_cdata <= '0;
                r_sticky      <= '0;
                r_snap_valid  <= 1'b0;
                r_snap_vreg   <= '0;
                r_snap_creg   <= '0;
            end else if (w_step_acc) begin
                r_cycles <= w_cyc_n;
                r_mcnt   <= w_mcnt_nxt;
                r_sticky <= r_sticky | w_diff;
                if (!r_first_valid && w_any) begin
                    r_first_valid <= 1'b1;
                    r_first_cycle <= w_cyc_n;
                    r_first_reg   <= w_first_idx;
                    r_first_vdata <= w_first_vdata;
                    r_first_cdata <= w_first_cdata;
                end
                if ((snap_cycle != '0) && (w_cyc_n == snap_cycle)) begin
                    r_snap_valid <= 1'b1;
                    r_snap_vreg  <= vreg;
                    r_snap_creg  <= creg;
                end
            end
            // Verdict includes the final step's contribution.
            if (w_to_done) begin
                r_pass <= (w_mcnt_nxt == '0);
            end
        end
    end

    assign busy         = (r_state == RUN);
    assign done         = (r_state == DONE);
    assign pass         = r_pass;
    assign cycles       = r_cycles;
    assign mismatch_cnt = r_mcnt;
    assign first_valid  = r_first_valid;
    assign first_cycle  = r_first_cycle;
    assign first_reg    = r_first_reg;
    assign first_vdata  = r_first_vdata;
    assign first_cdata  = r_first_cdata;
    assign sticky       = r_sticky;
    assign snap_valid   = r_snap_valid;
    assign snap_vreg    = r_snap_vreg;
    assign snap_creg    = r_snap_creg;

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: expected run results are queued at run start and checked at done.
module tb_lockstep_checker;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int MW = 4;
    localparam int IW = 5;
    localparam int BW = NR * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          step = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic [CW-1:0] snap_cycle = '0;
    logic [NR-1:0] mask = '0;
    logic [BW-1:0] vreg = '0;
    logic [BW-1:0] creg = '0;

    logic          busy, done, pass, first_valid, snap_valid;
    logic [CW-1:0] cycles, first_cycle;
    logic [MW-1:0] mismatch_cnt;
    logic [IW-1:0] first_reg;
    logic [DW-1:0] first_vdata, first_cdata;
    logic [NR-1:0] sticky;
    logic [BW-1:0] snap_vreg, snap_creg;

    lockstep_checker #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .CYC_W    (CW),
        .CNT_W    (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .step         (step),
        .num_cycles   (num_cycles),
        .snap_cycle   (snap_cycle),
        .mask         (mask),
        .vreg         (vreg),
        .creg         (creg),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .cycles       (cycles),
        .mismatch_cnt (mismatch_cnt),
        .first_valid  (first_valid),
        .first_cycle  (first_cycle),
        .first_reg    (first_reg),
        .first_vdata  (first_vdata),
        .first_cdata  (first_cdata),
        .sticky       (sticky),
        .snap_valid   (snap_valid),
        .snap_vreg    (snap_vreg),
        .snap_creg    (snap_creg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          pass;
        logic [CW-1:0] cyc;
        logic [MW-1:0] mcnt;
        logic          fvalid;
        logic [CW-1:0] fcyc;
        logic [IW-1:0] freg;
        logic [DW-1:0] fvdata;
        logic [DW-1:0] fcdata;
        logic [NR-1:0] sticky;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] put_reg(input logic [BW-1:0] bus, input int idx,
                                              input logic [DW-1:0] val);
        logic [BW-1:0] b;
        b = bus;
        b[(NR - 1 - idx) * DW +: DW] = val;
        return b;
    endfunction

    task automatic push_exp(input logic p, input int cyc, input int mcnt, input logic fv,
                            input int fcyc, input int freg, input logic [DW-1:0] fvd,
                            input logic [DW-1:0] fcd, input logic [NR-1:0] stk);
        exp_t e;
        e.pass   = p;
        e.cyc    = CW'(cyc);
        e.mcnt   = MW'(mcnt);
        e.fvalid = fv;
        e.fcyc   = CW'(fcyc);
        e.freg   = IW'(freg);
        e.fvdata = fvd;
        e.fcdata = fcd;
        e.sticky = stk;
        sb.push_back(e);
    endtask

    task automatic do_step(input logic [BW-1:0] v, input logic [BW-1:0] c);
        vreg = v;
        creg = c;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic start_run(input int nc, input int sc, input logic [NR-1:0] m);
        num_cycles = CW'(nc);
        snap_cycle = CW'(sc);
        mask       = m;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_cycles", cycles, 0);
        chk("start_mcnt", mismatch_cnt, 0);
        chk("start_pass", pass, 0);
        chk("start_first_valid", first_valid, 0);
        chk("start_sticky", sticky, 0);
        chk("start_snap_valid", snap_valid, 0);
    endtask

    task automatic expect_done(input int budget);
        exp_t e;
        int   k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk("done_pulse", done, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_pass", pass, e.pass);
            chk("res_cycles", cycles, e.cyc);
            chk("res_mcnt", mismatch_cnt, e.mcnt);
            chk("res_first_valid", first_valid, e.fvalid);
            chk("res_sticky", sticky, e.sticky);
            if (e.fvalid) begin
                chk("res_first_cycle", first_cycle, e.fcyc);
                chk("res_first_reg", first_reg, e.freg);
                chk("res_first_vdata", first_vdata, e.fvdata);
                chk("res_first_cdata", first_cdata, e.fcdata);
            end
        end
    endtask

    initial begin
        logic [BW-1:0] v, c, v4, c4;
        logic          saw_done;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_mcnt", mismatch_cnt, 0);
        chk("rst_first_valid", first_valid, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_snap_vreg_zero", snap_vreg === '0, 1);

        // stop in IDLE does nothing
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_done", done, 0);

        // 1: identical buses, 10 steps back to back
        start_run(10, 0, '1);
        push_exp(1'b1, 10, 0, 1'b0, 0, 0, '0, '0, '0);
        step = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            v = {NR{32'($urandom())}};
            vreg = v;
            creg = v;
            tick();
            if (i == 1) chk("t1_first_step_cycles", cycles, 1);
            if (i == 9) chk("t1_no_early_done", done, 0);
        end
        step = 1'b0;
        expect_done(0);
        tick();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_pass_held", pass, 1);

        // 2: single mismatch on reg 5 at step 3
        start_run(5, 0, '1);
        push_exp(1'b0, 5, 1, 1'b1, 3, 5, 32'hDEADBEEF, 32'h0, 32'h20);
        for (int s = 1; s <= 5; s++) begin
            v = (s == 3) ? put_reg('0, 5, 32'hDEADBEEF) : '0;
            do_step(v, '0);
        end
        expect_done(0);
        tick();

        // 3: regs 2 and 7 differ on steps 4..6, reg 7 masked off
        start_run(8, 0, ~(32'h1 << 7));
        push_exp(1'b0, 8, 3, 1'b1, 4, 2, 32'h1004, 32'h0, 32'h4);
        for (int s = 1; s <= 8; s++) begin
            v = '0;
            if (s >= 4 && s <= 6) v = put_reg(put_reg('0, 2, 32'h1000 + s), 7, 32'h7777);
            do_step(v, '0);
        end
        expect_done(0);
        tick();

        // 4: snapshot at step 4, mask all off so differing buses still pass
        start_run(6, 4, '0);
        push_exp(1'b1, 6, 0, 1'b0, 0, 0, '0, '0, '0);
        v4 = '0;
        c4 = '0;
        for (int s = 1; s <= 6; s++) begin
            v = '0;
            for (int r = 0; r < NR; r++) v = put_reg(v, r, {8'(s), 8'(r), 16'hA5C3});
            c = ~v;
            if (s == 4) begin
                v4 = v;
                c4 = c;
            end
            do_step(v, c);
            if (s == 3) chk("t4_snap_not_yet", snap_valid, 0);
            if (s == 4) begin
                chk("t4_snap_valid", snap_valid, 1);
                chk("t4_snap_vreg_match", snap_vreg === v4, 1);
                chk("t4_snap_creg_match", snap_creg === c4, 1);
            end
        end
        chk("t4_snap_vreg_held", snap_vreg === v4, 1);
        chk("t4_snap_creg_held", snap_creg === c4, 1);
        expect_done(0);
        tick();

        // 5: unbounded, step every other cycle, start mid-run ignored, stop with 6th step
        start_run(0, 0, '1);
        push_exp(1'b1, 5, 0, 1'b0, 0, 0, '0, '0, '0);
        for (int s = 1; s <= 5; s++) begin
            do_step('0, '0);
            if (s == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("t5_start_in_run_cycles", cycles, 2);
                chk("t5_start_in_run_busy", busy, 1);
            end else begin
                tick();
            end
        end
        stop = 1'b1;
        do_step('0, '0);
        stop = 1'b0;
        expect_done(0);
        tick();

        // 5b: unbounded run saturates the cycle counter
        start_run(0, 0, '1);
        push_exp(1'b1, 15, 0, 1'b0, 0, 0, '0, '0, '0);
        for (int s = 1; s <= 20; s++) do_step('0, '0);
        chk("t5b_still_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_done(0);
        tick();

        // 6: all registers differ -> saturated mismatch count; start in DONE ignored
        start_run(3, 0, '1);
        push_exp(1'b0, 3, 15, 1'b1, 1, 0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        do_step('1, '0);
        do_step(put_reg('0, 9, 32'h1), '0);
        do_step('0, '0);
        start = 1'b1;
        expect_done(0);
        tick();
        start = 1'b0;
        chk("t6_start_in_done_busy", busy, 0);
        chk("t6_start_in_done_mcnt", mismatch_cnt, 15);

        // 7: reset mid-run clears everything and never pulses done
        start_run(10, 2, '1);
        do_step('1, '0);
        do_step('1, '0);
        chk("t7_mcnt_before_rst", mismatch_cnt, 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        step = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        step = 1'b0;
        chk("t7_no_done", saw_done, 0);
        chk("t7_busy", busy, 0);
        chk("t7_cycles", cycles, 0);
        chk("t7_mcnt", mismatch_cnt, 0);
        chk("t7_pass", pass, 0);
        chk("t7_first_valid", first_valid, 0);
        chk("t7_first_reg", first_reg, 0);
        chk("t7_first_vdata", first_vdata, 0);
        chk("t7_sticky", sticky, 0);
        chk("t7_snap_valid", snap_valid, 0);
        chk("t7_snap_vreg_zero", snap_vreg === '0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
Synthesizable lockstep register-file comparator for the processor verification flow. Each counted cycle it compares two flattened register-file buses, the Verilog processor and the C++ reference model, register by register. It accumulates mismatch statistics, captures the first divergence and an optional full-state snapshot, and terminates the run after a programmed cycle count. It generalises the bench-side compare loop in three ways: parametrised register count and width, a per-register compare mask, and hardware result registers.

Parameters:
NUM_REGS, 32, registers per bus
DATA_W, 32, bits per register
CYC_W, 32, cycle counter width
CNT_W, 16, mismatch counter width (saturating)
IDX_W (localparam), $clog2(NUM_REGS), register index width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  pulse; begins a run from IDLE
stop  in  1  abort a run in progress
step  in  1  one processor cycle completed; sample the buses
num_cycles  in  CYC_W  run length in steps; 0 = unbounded
snap_cycle  in  CYC_W  step number at which to snapshot; 0 = disabled
mask  in  NUM_REGS  bit i = 1 compares register i
vreg  in  NUM_REGS*DATA_W  DUT registers; reg i = bits [NUM_REGS*DATA_W-1-i*DATA_W -: DATA_W]
creg  in  NUM_REGS*DATA_W  reference registers; same packing as vreg
busy  out  1  high in RUN
done  out  1  one-cycle pulse at end of run
pass  out  1  valid from the done pulse; 1 = zero mismatches
cycles  out  CYC_W  steps counted
mismatch_cnt  out  CNT_W  total per-register mismatches
first_valid  out  1  first-divergence fields valid
first_cycle  out  CYC_W  step number of first divergence
first_reg  out  IDX_W  lowest mismatching index at first divergence
first_vdata  out  DATA_W  DUT value of first_reg at that step
first_cdata  out  DATA_W  reference value of first_reg at that step
sticky  out  NUM_REGS  OR of the mismatch vectors over the run
snap_valid  out  1  snapshot captured
snap_vreg  out  NUM_REGS*DATA_W  captured DUT bus
snap_creg  out  NUM_REGS*DATA_W  captured reference bus

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-high. All outputs are 0 after reset and the FSM is in IDLE. rst mid-run aborts the run, produces no done pulse and clears all results.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: stop, or end of run -> DONE.
  - DONE: lasts exactly 1 cycle with done=1, then -> IDLE.
- start behaviour: the start edge clears cycles, mismatch_cnt, first_*, sticky, snap_* and pass. start in RUN or DONE is ignored. Results hold in IDLE until the next start.
- Mismatch vector: diff[i] = mask[i] & (vreg_i != creg_i). The compare uses full 2-state equality.
- Per step: on an edge in RUN with step=1 and stop=0 (n = cycles+1):
  - cycles <= n.
  - mismatch_cnt <= sat(mismatch_cnt + popcount(diff)), clamped at 2^CNT_W-1.
  - sticky <= sticky | diff.
  - If !first_valid and diff != 0: capture first_cycle=n, first_reg=lowest set index, and its vdata/cdata, then set first_valid.
  - If snap_cycle != 0 and n == snap_cycle: capture vreg/creg and set snap_valid.
  - If num_cycles != 0 and n == num_cycles: -> DONE.
- Latency: all updates are visible the cycle after the sampling edge; done is asserted the cycle after the final step.
- stop has priority: a step on the same edge is not counted. stop in IDLE is ignored.
- pass = (mismatch_cnt == 0), computed with the final update and registered entering DONE.
- A step edge is counted only in RUN.
- Wrap: cycles saturates at 2^CYC_W-1 when num_cycles=0.

Decomposition:
- Shared package/header lockstep_pkg:
  - FSM encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default NUM_REGS/DATA_W.
  - Register-slice macro/function for the MSB-first packing.
- Sub-module lockstep_diff (combinational), owning the per-register compare, popcount and lowest-index priority encoder:
  - Outputs: diff vector, popcount, first index, any flag.
  - Parametrised identically to the top.

Test Plan:
1. Identical buses, num_cycles=10, step every cycle -> done pulse 1 cycle after the 10th step; pass=1, cycles=10, mismatch_cnt=0, sticky=0.
2. reg5 vreg=0xDEADBEEF vs creg=0 on step 3 only -> first_cycle=3, first_reg=5, first_vdata=0xDEADBEEF, first_cdata=0, mismatch_cnt=1, sticky=0x20, pass=0.
3. regs 2 and 7 differ on steps 4..6, mask[7]=0 -> mismatch_cnt=3, first_reg=2, first_cycle=4, sticky=0x4.
4. snap_cycle=4, distinct bus values each step -> snap_valid after the 4th step; snap_vreg/snap_creg equal the step-4 inputs and are unchanged by later steps.
5. num_cycles=0, step every other cycle, stop asserted with step on the 6th step edge -> cycles=5, done pulses; start during RUN ignored.
6. CNT_W=4, all 32 registers differ for 1 step -> mismatch_cnt=15 (saturated). Assert rst mid-run -> no done pulse, all outputs 0, busy=0.
